// File: rtl/io_channel_ctrl_if.sv
// Memory write port between the I/O channel controller and the CPU memory.
// The controller drives the master side; the memory returns a one-cycle ack.
interface io_channel_ctrl_if;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic [29:0] mem_data;
    logic        mem_ack;

    modport master (output mem_req, output mem_addr, output mem_data, input mem_ack);
    modport slave  (input mem_req, input mem_addr, input mem_data, output mem_ack);
endinterface

// File: rtl/io_channel_ctrl.sv
// MIX I/O channel controller: unit decode, start/query/stop handling and a
// round-robin store arbiter. Optional watchdog under macro IO_WATCHDOG_EN.
module io_channel_ctrl #(
    parameter logic [5:0]  UNIT0     = 6'd16,
    parameter logic [5:0]  UNIT1     = 6'd19,
    parameter logic [5:0]  UNIT2     = 6'd18,
    parameter logic [5:0]  UNIT3     = 6'd0,
    parameter logic [23:0] WD_CYCLES = 24'd12000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [5:0]                field,
    input  logic [11:0]               addressin,
    input  logic                      query,
    output logic                      query_busy,
    output logic                      stop,
    output logic                      illegal,
    output logic [3:0]                ch_start,
    output logic [5:0]                ch_field,
    output logic [11:0]               ch_address,
    input  logic [3:0]                ch_busy,
    input  logic [3:0]                ch_stop,
    input  logic [3:0]                ch_request,
    input  logic [29:0]               ch_word0,
    input  logic [29:0]               ch_word1,
    input  logic [29:0]               ch_word2,
    input  logic [29:0]               ch_word3,
    input  logic [11:0]               ch_addr0,
    input  logic [11:0]               ch_addr1,
    input  logic [11:0]               ch_addr2,
    input  logic [11:0]               ch_addr3,
    output logic [3:0]                ch_store,
    io_channel_ctrl_if.master         mem,
    output logic                      io_fault
);

    typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_WAIT = 2'd1, ARB_HOLD = 2'd2} arb_state_t;

    // First requesting channel at or after the pointer, wrapping 3 -> 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + i[1:0];
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    logic [3:0]  unit_match_s;
    logic        any_match_s;
    logic        wd_trip_s;
    logic        ack_s;
    logic [1:0]  pick_s;
    logic [3:0]  ch_store_s;
    logic [11:0] addr_arr_s [4];
    logic [29:0] word_arr_s [4];

    logic        query_busy_r;
    logic        stop_r;
    logic        illegal_r;
    logic [3:0]  ch_start_r;
    logic [5:0]  ch_field_r;
    logic [11:0] ch_address_r;

    arb_state_t  state_r, state_s;
    logic [1:0]  ptr_r;
    logic [1:0]  grant_r;
    logic        mem_req_r;
    logic [11:0] mem_addr_r;
    logic [29:0] mem_data_r;

    assign addr_arr_s[0] = ch_addr0;
    assign addr_arr_s[1] = ch_addr1;
    assign addr_arr_s[2] = ch_addr2;
    assign addr_arr_s[3] = ch_addr3;
    assign word_arr_s[0] = ch_word0;
    assign word_arr_s[1] = ch_word1;
    assign word_arr_s[2] = ch_word2;
    assign word_arr_s[3] = ch_word3;

    // Unit number decode shared by the start and query paths.
    always_comb begin
        unit_match_s[0] = (field == UNIT0);
        unit_match_s[1] = (field == UNIT1);
        unit_match_s[2] = (field == UNIT2);
        unit_match_s[3] = (field == UNIT3);
        any_match_s     = |unit_match_s;
    end

    // Start, query, illegal and stop registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_start_r   <= 4'b0000;
            ch_field_r   <= 6'd0;
            ch_address_r <= 12'd0;
            illegal_r    <= 1'b0;
            stop_r       <= 1'b0;
            query_busy_r <= 1'b0;
        end else begin
            ch_start_r <= start ? unit_match_s : 4'b0000;
            if (start && any_match_s) begin
                ch_field_r   <= field;
                ch_address_r <= addressin;
            end
            illegal_r    <= (start | query) & ~any_match_s;
            stop_r       <= (|ch_stop) | (start & ~any_match_s) | wd_trip_s;
            // Samples ch_busy as it stands, so a same-cycle start is not yet visible.
            query_busy_r <= query & (|(ch_busy & unit_match_s));
        end
    end

    assign pick_s = rr_pick(ch_request, ptr_r);
    assign ack_s  = (state_r == ARB_WAIT) & mem.mem_ack & ~reset;

    // Arbiter next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (|ch_request) state_s = ARB_WAIT;
                else             state_s = ARB_IDLE;
            end
            ARB_WAIT: begin
                if (ack_s) state_s = ARB_HOLD;
                else       state_s = ARB_WAIT;
            end
            ARB_HOLD: state_s = ARB_IDLE;
            default:  state_s = ARB_IDLE;
        endcase
    end

    // Arbiter state, pointer and latched write request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ARB_IDLE;
            ptr_r      <= 2'd0;
            grant_r    <= 2'd0;
            mem_req_r  <= 1'b0;
            mem_addr_r <= 12'd0;
            mem_data_r <= 30'd0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ARB_IDLE: begin
                    if (|ch_request) begin
                        grant_r    <= pick_s;
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= addr_arr_s[pick_s];
                        mem_data_r <= word_arr_s[pick_s];
                    end
                end
                ARB_WAIT: begin
                    if (ack_s) begin
                        mem_req_r <= 1'b0;
                        ptr_r     <= grant_r + 2'd1;
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Store acknowledge follows mem_ack in the same cycle.
    always_comb begin
        ch_store_s = 4'b0000;
        if (ack_s) ch_store_s[grant_r] = 1'b1;
        else       ch_store_s = 4'b0000;
    end

`ifdef IO_WATCHDOG_EN
    logic [23:0] wd_cnt_r;
    logic        wd_fault_r;

    assign wd_trip_s = (|ch_busy) & ~mem.mem_ack & ~wd_fault_r & (wd_cnt_r == (WD_CYCLES - 24'd1));

    // Busy-without-progress counter and sticky fault flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_r   <= 24'd0;
            wd_fault_r <= 1'b0;
        end else begin
            if (mem.mem_ack || (ch_busy == 4'b0000)) wd_cnt_r <= 24'd0;
            else if (wd_cnt_r != WD_CYCLES)          wd_cnt_r <= wd_cnt_r + 24'd1;
            if (wd_trip_s) wd_fault_r <= 1'b1;
        end
    end

    assign io_fault = wd_fault_r;
`else
    logic unused_wd_s;
    assign unused_wd_s = ^WD_CYCLES;
    assign wd_trip_s   = 1'b0;
    assign io_fault    = 1'b0;
`endif

    assign query_busy   = query_busy_r;
    assign stop         = stop_r;
    assign illegal      = illegal_r;
    assign ch_start     = ch_start_r;
    assign ch_field     = ch_field_r;
    assign ch_address   = ch_address_r;
    assign ch_store     = ch_store_s;
    assign mem.mem_req  = mem_req_r;
    assign mem.mem_addr = mem_addr_r;
    assign mem.mem_data = mem_data_r;

endmodule

// File: tb/tb_io_channel_ctrl.sv
// Directed self-checking bench for io_channel_ctrl; exercises the watchdog
// only when IO_WATCHDOG_EN is defined (WD_CYCLES overridden to 20).
module tb_io_channel_ctrl;
    logic        clk = 1'b0;
    logic        reset, start, query;
    logic [5:0]  field;
    logic [11:0] addressin;
    logic        query_busy, stop, illegal, io_fault;
    logic [3:0]  ch_start, ch_busy, ch_stop, ch_request, ch_store;
    logic [5:0]  ch_field;
    logic [11:0] ch_address;
    logic [29:0] ch_word0, ch_word1, ch_word2, ch_word3;
    logic [11:0] ch_addr0, ch_addr1, ch_addr2, ch_addr3;
    int          checks_cnt = 0;
    int          fail_cnt   = 0;
    logic [3:0]  rr_exp [5];

    io_channel_ctrl_if mem_if ();

    io_channel_ctrl #(.WD_CYCLES(24'd20)) dut (
        .clk(clk), .reset(reset), .start(start), .field(field), .addressin(addressin),
        .query(query), .query_busy(query_busy), .stop(stop), .illegal(illegal),
        .ch_start(ch_start), .ch_field(ch_field), .ch_address(ch_address),
        .ch_busy(ch_busy), .ch_stop(ch_stop), .ch_request(ch_request),
        .ch_word0(ch_word0), .ch_word1(ch_word1), .ch_word2(ch_word2), .ch_word3(ch_word3),
        .ch_addr0(ch_addr0), .ch_addr1(ch_addr1), .ch_addr2(ch_addr2), .ch_addr3(ch_addr3),
        .ch_store(ch_store), .mem(mem_if), .io_fault(io_fault)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic wait_req;
        int n;
        n = 0;
        while (!mem_if.mem_req && n < 10) begin
            tick;
            n++;
        end
        check_val("req_timeout", {31'd0, mem_if.mem_req}, 32'd1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; query = 1'b0; field = 6'd0; addressin = 12'd0;
        ch_busy = 4'b0000; ch_stop = 4'b0000; ch_request = 4'b0000;
        ch_addr0 = 12'd10; ch_addr1 = 12'd11; ch_addr2 = 12'd12; ch_addr3 = 12'd13;
        ch_word0 = 30'h100; ch_word1 = 30'h101; ch_word2 = 30'h102; ch_word3 = 30'h103;
        mem_if.mem_ack = 1'b0;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

        do_reset;
        check_val("rst_ch_start", ch_start, 4'b0000);
        check_val("rst_stop", stop, 1'b0);
        check_val("rst_illegal", illegal, 1'b0);
        check_val("rst_mem_req", mem_if.mem_req, 1'b0);
        check_val("rst_ch_store", ch_store, 4'b0000);
        check_val("rst_query_busy", query_busy, 1'b0);
        check_val("rst_io_fault", io_fault, 1'b0);

        // Start to unit 16 (channel 0)
        field = 6'd16; addressin = 12'd100; start = 1'b1;
        tick;
        start = 1'b0;
        check_val("start_ch_start", ch_start, 4'b0001);
        check_val("start_ch_field", ch_field, 6'd16);
        check_val("start_ch_address", ch_address, 12'd100);
        check_val("start_no_stop", stop, 1'b0);
        tick;
        check_val("start_pulse_end", ch_start, 4'b0000);
        check_val("start_still_no_stop", stop, 1'b0);
        ch_stop = 4'b0001;
        tick;
        ch_stop = 4'b0000;
        check_val("chstop_stop", stop, 1'b1);
        tick;
        check_val("chstop_stop_end", stop, 1'b0);

        // Start to unmapped unit 7
        field = 6'd7; addressin = 12'd55; start = 1'b1;
        tick;
        start = 1'b0;
        check_val("illegal_ch_start", ch_start, 4'b0000);
        check_val("illegal_pulse", illegal, 1'b1);
        check_val("illegal_stop", stop, 1'b1);
        check_val("illegal_keeps_addr", ch_address, 12'd100);
        tick;
        check_val("illegal_end", illegal, 1'b0);
        check_val("illegal_stop_end", stop, 1'b0);

        // Single store from channel 1; request drop and word change must not disturb it
        ch_request = 4'b0010; ch_addr1 = 12'd200; ch_word1 = 30'h1234567;
        tick;
        check_val("st_mem_req", mem_if.mem_req, 1'b1);
        check_val("st_mem_addr", mem_if.mem_addr, 12'd200);
        check_val("st_mem_data", mem_if.mem_data, 30'h1234567);
        ch_request = 4'b0000; ch_word1 = 30'h0; ch_addr1 = 12'd11;
        tick;
        check_val("st_no_store_early", ch_store, 4'b0000);
        tick;
        check_val("st_hold_req", mem_if.mem_req, 1'b1);
        check_val("st_hold_addr", mem_if.mem_addr, 12'd200);
        check_val("st_hold_data", mem_if.mem_data, 30'h1234567);
        mem_if.mem_ack = 1'b1;
        #1;
        check_val("st_ch_store", ch_store, 4'b0010);
        tick;
        mem_if.mem_ack = 1'b0;
        #1;
        check_val("st_req_drop", mem_if.mem_req, 1'b0);
        check_val("st_store_end", ch_store, 4'b0000);
        tick;
        mem_if.mem_ack = 1'b1;
        #1;
        check_val("idle_ack_ignored", ch_store, 4'b0000);
        tick;
        mem_if.mem_ack = 1'b0;
        check_val("idle_ack_no_req", mem_if.mem_req, 1'b0);

        // Round-robin fairness with all requests held
        do_reset;
        ch_request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_req;
            check_val($sformatf("rr_addr%0d", k), mem_if.mem_addr,
                      (rr_exp[k] == 4'b0001) ? 32'd10 : (rr_exp[k] == 4'b0010) ? 32'd11 :
                      (rr_exp[k] == 4'b0100) ? 32'd12 : 32'd13);
            tick;
            mem_if.mem_ack = 1'b1;
            #1;
            check_val($sformatf("rr_store%0d", k), ch_store, rr_exp[k]);
            tick;
            mem_if.mem_ack = 1'b0;
        end
        ch_request = 4'b0000;
        tick;
        tick;

        // Busy queries
        ch_busy = 4'b0010; field = 6'd19; query = 1'b1;
        tick;
        query = 1'b0;
        check_val("q19_busy", query_busy, 1'b1);
        check_val("q19_legal", illegal, 1'b0);
        field = 6'd16; query = 1'b1;
        tick;
        query = 1'b0;
        check_val("q16_busy", query_busy, 1'b0);
        field = 6'd7; query = 1'b1;
        tick;
        query = 1'b0;
        check_val("q7_busy", query_busy, 1'b0);
        check_val("q7_illegal", illegal, 1'b1);
        check_val("q7_no_stop", stop, 1'b0);
        ch_busy = 4'b0000;

        // Reset in WAIT: no store, pointer returns to 0 (it was 1 before)
        ch_request = 4'b0100;
        tick;
        check_val("rw_req", mem_if.mem_req, 1'b1);
        check_val("rw_addr", mem_if.mem_addr, 12'd12);
        reset = 1'b1; mem_if.mem_ack = 1'b1; ch_request = 4'b1111;
        #1;
        check_val("rw_no_store", ch_store, 4'b0000);
        tick;
        reset = 1'b0; mem_if.mem_ack = 1'b0;
        check_val("rw_req_drop", mem_if.mem_req, 1'b0);
        tick;
        check_val("rw_ptr0_addr", mem_if.mem_addr, 12'd10);
        mem_if.mem_ack = 1'b1;
        #1;
        check_val("rw_ptr0_store", ch_store, 4'b0001);
        tick;
        mem_if.mem_ack = 1'b0;
        ch_request = 4'b0000;
        tick;
        tick;

        // Watchdog
        do_reset;
        ch_busy = 4'b0001;
        repeat (19) tick;
        check_val("wd_not_yet", io_fault, 1'b0);
`ifdef IO_WATCHDOG_EN
        tick;
        check_val("wd_fault", io_fault, 1'b1);
        check_val("wd_stop", stop, 1'b1);
        tick;
        check_val("wd_stop_once", stop, 1'b0);
        ch_busy = 4'b0000;
        repeat (3) tick;
        check_val("wd_sticky", io_fault, 1'b1);
        do_reset;
        check_val("wd_reset_clears", io_fault, 1'b0);
`else
        repeat (10) tick;
        check_val("wd_off_fault", io_fault, 1'b0);
        check_val("wd_off_stop", stop, 1'b0);
`endif
        ch_busy = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end
endmodule
